// File: rtl/general_adder.sv
// Combinational FP32 + BF16 adder, round-to-nearest-even, with subnormal support.
// The BF16 operand is widened to FP32 by appending 16 zero mantissa bits.
module general_adder (
  input  logic [31:0] a,
  input  logic [15:0] b,
  output logic [31:0] sum
);
  logic [31:0] w_b32, w_big, w_sml;
  logic [7:0]  w_eb, w_es, w_diff;
  logic [26:0] w_mb, w_ms, w_ms_sh;
  logic [27:0] w_sum, w_norm;
  logic [24:0] w_mant;
  logic [9:0]  w_exp;
  logic        w_sub, w_rnd, w_sign;
  logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  always_comb begin
    w_b32   = {b, 16'h0000};
    w_a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    w_a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    w_b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    w_b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);

    if (a[30:0] >= w_b32[30:0]) begin
      w_big = a;
      w_sml = w_b32;
    end else begin
      w_big = w_b32;
      w_sml = a;
    end

    // Mantissas carry guard, round and sticky bits below the LSB
    w_eb   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_es   = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    w_mb   = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
    w_ms   = {(w_sml[30:23] != 8'd0), w_sml[22:0], 3'b000};
    w_diff = w_eb - w_es;
    if (w_diff >= 8'd27) begin
      w_ms_sh = {26'd0, |w_ms};
    end else begin
      w_ms_sh = (w_ms >> w_diff) | {26'd0, |(w_ms & ((27'd1 << w_diff) - 27'd1))};
    end

    w_sub = w_big[31] ^ w_sml[31];
    w_sum = w_sub ? ({1'b0, w_mb} - {1'b0, w_ms_sh}) : ({1'b0, w_mb} + {1'b0, w_ms_sh});

    w_exp  = {2'b00, w_eb};
    w_norm = w_sum;
    if (w_sum[27]) begin
      w_norm = {1'b0, w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = w_exp + 10'd1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        if (!w_norm[26] && (w_exp > 10'd1)) begin
          w_norm = w_norm << 1;
          w_exp  = w_exp - 10'd1;
        end
      end
    end

    w_rnd  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    if (w_mant[24]) begin
      w_mant = {1'b0, w_mant[24:1]};
      w_exp  = w_exp + 10'd1;
    end

    // Exact cancellation yields +0 under round-to-nearest
    w_sign = (w_sub && (w_sum == 28'd0)) ? 1'b0 : w_big[31];

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[15]))) begin
      sum = 32'h7FC0_0000;
    end else if (w_a_inf) begin
      sum = {a[31], 8'hFF, 23'd0};
    end else if (w_b_inf) begin
      sum = {b[15], 8'hFF, 23'd0};
    end else if (w_exp >= 10'd255) begin
      sum = {w_sign, 8'hFF, 23'd0};
    end else begin
      sum = {w_sign, (w_mant[23] ? w_exp[7:0] : 8'd0), w_mant[22:0]};
    end
  end
endmodule

// File: rtl/fp32_stream_accumulator.sv
// Streams BF16 beats into an FP32 running sum; emits the sum and beat count per vector.
// A one-beat input stage feeds the adder, so the last beat folds in one edge after acceptance.
module fp32_stream_accumulator #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDone} state_e;

  state_e           r_state, w_state_nxt;
  logic [31:0]      r_acc, w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_in_q;
  logic             r_in_q_v, r_last_q, r_live;
  logic             w_accept, w_handshake;

  general_adder u_adder (
    .a   (r_acc),
    .b   (r_in_q),
    .sum (w_sum)
  );

  // r_live keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready    = r_live && !clr && ((r_state == StIdle) || (r_state == StAccum));
    w_accept    = in_valid && in_ready;
    out_valid   = (r_state == StDone) && r_last_q;
    w_handshake = out_valid && out_ready;
    out_data    = r_acc;
    out_count   = r_cnt;
    busy        = (r_state != StIdle);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_accept) w_state_nxt = in_last ? StFlush : StAccum;
        StAccum: if (w_accept && in_last) w_state_nxt = StFlush;
        StFlush: w_state_nxt = StDone;
        StDone:  if (w_handshake) w_state_nxt = StIdle;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_acc    <= 32'h0;
      r_cnt    <= '0;
      r_in_q   <= 16'h0;
      r_in_q_v <= 1'b0;
      r_last_q <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      if (clr) begin
        r_acc    <= 32'h0;
        r_cnt    <= '0;
        r_in_q_v <= 1'b0;
      end else begin
        r_in_q_v <= w_accept;
        if (w_accept) begin
          r_in_q   <= in_data;
          r_last_q <= in_last;
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_handshake) begin
          r_acc <= 32'h0;
          r_cnt <= '0;
        end else if (r_in_q_v) begin
          r_acc <= w_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp32_stream_accumulator.sv
// Table-driven bench with a result scoreboard, plus hand-written latency,
// backpressure, clr and reset sequences. A 2-bit-counter instance checks saturation.
module tb_fp32_stream_accumulator;
  localparam int CNT_W = 16;
  localparam int SAT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic [15:0]      in_data = 16'h0;
  logic             in_ready, out_valid, busy;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             s_in_ready, s_out_valid, s_busy;
  logic [31:0]      s_out_data;
  logic [1:0]       s_out_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    int          count;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          n;
    logic [95:0] beats;  // first beat in the top 16 bits
    logic [31:0] data;
    int          count;
  } vec_t;

  fp32_stream_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  fp32_stream_accumulator #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_count (s_out_count),
    .busy      (s_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Results are compared at the negedge before the handshake edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        fail("unexpected result");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_count", 32'(out_count), e.count);
        chk("sat out_valid", {31'd0, s_out_valid}, 32'd1);
        chk("sat out_data", s_out_data, e.data);
        chk("sat out_count", 32'(s_out_count), (e.count > SAT_MAX) ? SAT_MAX : e.count);
      end
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail("in_ready wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input vec_t v, input logic push);
    exp_t e;
    e.data  = v.data;
    e.count = v.count;
    if (push) sb_q.push_back(e);
    for (int i = 0; i < v.n; i++) send_beat(v.beats[95 - 16*i -: 16], (i == v.n - 1));
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb_q.size() != 0) begin
      fail("drain");
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!out_valid) fail(name);
  endtask

  function automatic vec_t mk(input int n, input logic [95:0] beats, input logic [31:0] data,
                              input int count);
    vec_t v;
    v.n = n;
    v.beats = beats;
    v.data = data;
    v.count = count;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    vecs.push_back(mk(1, {16'h3F80, 80'h0}, 32'h3F80_0000, 1));
    vecs.push_back(mk(3, {16'h3F80, 16'h4000, 16'h3F80, 48'h0}, 32'h4080_0000, 3));
    vecs.push_back(mk(2, {16'h4000, 16'hBF80, 64'h0}, 32'h3F80_0000, 2));
    vecs.push_back(mk(5, {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0},
                      32'h40A0_0000, 5));
    vecs.push_back(mk(2, {16'h3F80, 16'hBF80, 64'h0}, 32'h0000_0000, 2));
    vecs.push_back(mk(2, {16'h4040, 16'h3F00, 64'h0}, 32'h4060_0000, 2));
    vecs.push_back(mk(2, {16'h4B80, 16'h3F80, 64'h0}, 32'h4B80_0000, 2));
    vecs.push_back(mk(2, {16'h4B80, 16'h4000, 64'h0}, 32'h4B80_0001, 2));
    vecs.push_back(mk(1, {16'hC2F6, 80'h0}, 32'hC2F6_0000, 1));
    vecs.push_back(mk(4, {16'h4120, 16'hC0A0, 16'h3E80, 16'hBE80, 32'h0}, 32'h40A0_0000, 4));

    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    foreach (vecs[k]) begin
      send_vec(vecs[k], 1'b1);
      drain();
    end

    // Latency: out_valid two edges after the last beat is accepted
    out_ready = 1'b0;
    send_vec(vecs[0], 1'b1);
    chk("latency edge1 out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("latency edge2 out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drain();
    chk("busy after handshake", {31'd0, busy}, 32'd0);

    // Busy across a vector, then backpressure in DONE
    out_ready = 1'b0;
    sb_q.push_back('{32'h4080_0000, 3});
    send_beat(16'h3F80, 1'b0);
    chk("busy beat1", {31'd0, busy}, 32'd1);
    send_beat(16'h4000, 1'b0);
    chk("busy beat2", {31'd0, busy}, 32'd1);
    send_beat(16'h3F80, 1'b1);
    chk("busy beat3", {31'd0, busy}, 32'd1);
    wait_valid("bp out_valid");
    for (int c = 0; c < 5; c++) begin
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp out_data", out_data, 32'h4080_0000);
      chk("bp out_count", 32'(out_count), 32'd3);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    chk("handshake in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post hs in_ready", {31'd0, in_ready}, 32'd1);
    chk("post hs acc", out_data, 32'd0);
    chk("post hs out_valid", {31'd0, out_valid}, 32'd0);
    chk("post hs busy", {31'd0, busy}, 32'd0);
    chk("bp scoreboard", 32'(sb_q.size()), 32'd0);

    // clr mid-vector, with a beat offered in the clr cycle
    send_beat(16'h4000, 1'b0);
    send_beat(16'h4000, 1'b0);
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h4000;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr busy", {31'd0, busy}, 32'd0);
    chk("clr acc", out_data, 32'd0);
    chk("clr count", 32'(out_count), 32'd0);
    send_vec(vecs[0], 1'b1);
    drain();

    // clr while a result is waiting in DONE
    out_ready = 1'b0;
    send_beat(16'h3F80, 1'b1);
    @(posedge clk);
    #1;
    chk("done before clr", {31'd0, out_valid}, 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr in done out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr in done out_data", out_data, 32'd0);
    out_ready = 1'b1;

    // Reset pulse in FLUSH
    send_beat(16'h3F80, 1'b0);
    send_beat(16'h4000, 1'b1);
    chk("in flush busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst flush in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst flush busy", {31'd0, busy}, 32'd0);
    chk("rst flush out_data", out_data, 32'd0);
    chk("rst flush out_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst flush in_ready back", {31'd0, in_ready}, 32'd1);
    send_vec(mk(1, {16'h4000, 80'h0}, 32'h4000_0000, 1), 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp32_stream_accumulator.md
FP32_STREAM_ACCUMULATOR -- requirements
Module: fp32_stream_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port clr, input, 1: synchronous abort; discards the vector in progress.
REQ-005 SHALL have port in_valid, input, 1: in_data, in_last valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-007 SHALL have port in_data, input, 16: BF16 operand (sign[15], exp[14:7], man[6:0]).
REQ-008 SHALL have port in_last, input, 1: final beat of the current vector.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port out_data, output, 32: FP32 accumulated sum.
REQ-012 SHALL have port out_count, output, CNT_W: number of beats summed into out_data.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, ACCUM, FLUSH and DONE.
REQ-015 SHALL hold registers acc[31:0], cnt[CNT_W-1:0] and an input stage in_q[15:0], in_q_v and last_q.
REQ-016 SHALL form the sum with one instance of the team's combinational FP32+BF16 adder (general_adder), driven with a=acc and b=in_q; no other arithmetic is permitted on acc.
REQ-017 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in FLUSH and DONE.
REQ-018 SHALL treat a beat as accepted at an edge where in_valid && in_ready; at that edge in_q<=in_data, in_q_v<=1, last_q<=in_last and cnt<=cnt+1, saturating at 2^CNT_W-1.
REQ-019 SHALL load in_q_v<=0 at any edge with no accepted beat.
REQ-020 SHALL load acc<=adder output at each edge where in_q_v=1; otherwise acc holds.
REQ-021 SHALL transition IDLE->ACCUM on an accepted beat with in_last=0, and IDLE->FLUSH on an accepted beat with in_last=1.
REQ-022 SHALL transition ACCUM->FLUSH on an accepted beat with in_last=1; otherwise ACCUM holds, and idle cycles with in_valid=0 are allowed.
REQ-023 SHALL transition FLUSH->DONE unconditionally on the next edge, which is the edge that folds the last beat into acc.
REQ-024 SHALL give a latency of 2 edges from acceptance of the last beat to out_valid=1.
REQ-025 SHALL assert out_valid=1 only in DONE, with out_data=acc and out_count=cnt held stable until the handshake.
REQ-026 SHALL, in DONE with out_ready=1, complete the handshake and on that edge set state<=IDLE, acc<=32'h0 and cnt<=0.
REQ-027 SHALL accept no new beat in the handshake cycle; in_ready rises the cycle after.
REQ-028 SHALL accept a single-beat vector, which returns the BF16 value zero-extended to FP32 (in_data<<16).
REQ-029 SHALL give clr priority over all other events in every state: next edge state<=IDLE, acc<=0, cnt<=0, in_q_v<=0, and no beat accepted in that cycle.
REQ-030 SHALL drive out_valid=0 in the cycle after clr, even if clr arrived in DONE.
REQ-031 SHALL, when cnt is saturated, continue accumulation with cnt held at its maximum value.
REQ-032 SHALL drive busy=(state!=IDLE).

Reset
REQ-033 SHALL, on rst_n=0 and asynchronously, set state=IDLE, acc=32'h0, cnt=0, in_q=0, in_q_v=0 and last_q=0.
REQ-034 SHALL, during reset, drive out_valid=0, in_ready=0, busy=0, out_data=32'h0 and out_count=0.
REQ-035 SHALL, on reset assertion mid-vector, discard all partial state; the first beat after release starts a new vector.
REQ-036 SHALL drive in_ready=1 from the first edge after rst_n deasserts.

Verification
REQ-037 SHALL cover a single beat: 16'h3F80 with last -> out_valid 2 edges later, out_data=32'h3F800000, out_count=1.
REQ-038 SHALL cover three beats: 3F80, 4000, 3F80 (last) back-to-back -> out_data=32'h40800000, out_count=3, busy high from the first accept until the handshake.
REQ-039 SHALL cover mixed signs: 4000 then BF80 (last) -> out_data=32'h3F800000, out_count=2.
REQ-040 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_data and out_count stable and in_ready=0; after the handshake, acc=0 and in_ready=1 the following cycle.
REQ-041 SHALL cover clr mid-vector: 4000, 4000, clr, then 3F80 (last) -> out_data=32'h3F800000, out_count=1.
REQ-042 SHALL cover rst_n pulse in FLUSH: all outputs are 0 immediately, and the next vector 4000 (last) -> out_data=32'h40000000, out_count=1.
